fft_frame_feeder: RTL and testbench
===================================

// Module: fft_frame_feeder
// PURPOSE
//  Frame-level master for fft_radix2. Buffers an N-sample complex stream from upstream,
//  pulses fft_start, pushes the frame over the FFT din_valid/din_ready port, captures the
//  FFT's dout_valid burst, and replays it downstream under valid/ready backpressure.
//  Sits between the sample source and the result sink in the DSP pipeline.
// PARAMETERS
//  N           8    points per frame; power of 2, 2..64; IDXW = $clog2(N)
//  DATA_WIDTH  16   signed width of real and imag parts
//  TIMEOUT     64   max wait cycles in WAIT_RDY or CAPTURE before abort; >= 2
// PORTS
//  clk             in   1    single clock, rising edge
//  rst_n           in   1    asynchronous active-low reset
//  flush           in   1    sync abort: drop the current frame, return to FILL
//  s_real,s_imag   in   DW   upstream sample (signed)
//  s_valid         in   1    upstream sample valid
//  s_ready         out  1    = (state==FILL) && !flush
//  fft_start       out  1    one-cycle start pulse to the FFT
//  fft_din_real/imag out DW  sample to the FFT
//  fft_din_valid   out  1    = (state==FEED)
//  fft_din_ready   in   1    FFT accepts samples
//  fft_dout_real/imag in DW  FFT result
//  fft_dout_valid  in   1    FFT result valid; no backpressure
//  m_real,m_imag   out  DW   downstream result
//  m_valid         out  1    = (state==DRAIN)
//  m_ready         in   1    downstream accept
//  frame_done      out  1    one-cycle pulse after the last result is accepted downstream
//  err_timeout     out  1    sticky; cleared by flush or reset
//  frame_count     out  16   count of completed frames; wraps at 0xFFFF->0
// BEHAVIOUR
//  Reset: state=FILL, all indices=0, fft_start=0, frame_done=0, err_timeout=0,
//   frame_count=0, m_real/m_imag/fft_din_*=0. Buffer contents are don't-care.
//  Handshakes: a transfer occurs on a cycle with valid&&ready. Data and valid stay stable
//   until accepted. m_* and fft_din_* are driven from the buffers at the current index.
//  FSM:
//   FILL     on s_valid&&s_ready: in_buf[wr_idx]<=s; wr_idx++. Transfer N-1 -> START.
//   START    fft_start=1 for this one cycle -> WAIT_RDY; wait counter cleared.
//   WAIT_RDY on fft_din_ready -> FEED. Counter reaches TIMEOUT -> set err, go FILL.
//   FEED     drives in_buf[rd_idx]; on fft_din_ready, rd_idx++. Transfer N-1 -> CAPTURE.
//            No timeout in FEED; a stalled ready holds the FSM here.
//   CAPTURE  each fft_dout_valid cycle: out_buf[cap_idx]<=fft_dout; cap_idx++.
//            Capture N-1 -> DRAIN. Counter (reset on every capture) reaching TIMEOUT
//            -> set err, go FILL, discard the partial frame.
//   DRAIN    on m_ready, dr_idx++. Transfer N-1: frame_done=1 the next cycle,
//            frame_count++, go FILL.
//  Boundaries:
//   - Index wraps to 0 on every state exit. The next frame's first sample is accepted in
//     the cycle after the DRAIN->FILL transition, never in the same cycle.
//   - s_ready is low outside FILL: no overlap between filling and draining.
//   - flush has priority over every event in the same cycle: -> FILL, indices=0,
//     err cleared, a coincident handshake is ignored, frame_done is not pulsed, and
//     frame_count is unchanged.
//   - fft_dout_valid outside CAPTURE is ignored.
//   - Async reset mid-frame drops the frame. No output glitches after release.
//  Latency: the FFT start pulse comes 1 cycle after the Nth input; first m_valid comes
//   1 cycle after the Nth capture.
// STRUCTURE
//  fft_pkg: state enum (FILL, START, WAIT_RDY, FEED, CAPTURE, DRAIN), default N/DW,
//   index-width function.
//  Sub-module frame_buf (N x 2*DW, one sync write port, async read), instantiated twice
//   (in_buf, out_buf). All FSM, counter and flag logic lives in the top level.
// TESTING
//  1 Feed s = k+j(-k), k=0..7, m_ready=1, FFT model echoes its input -> m stream equals
//    0..7; frame_done pulses once; frame_count=1.
//  2 Hold m_ready low for 5 cycles mid-DRAIN -> m_real/m_imag/m_valid hold stable;
//    no loss or duplication; s_ready=0 throughout.
//  3 fft_din_ready held low for 64 cycles after fft_start -> err_timeout=1, state FILL,
//    frame_count unchanged. Then flush -> err_timeout=0.
//  4 FFT model stops after 5 of 8 outputs -> timeout in CAPTURE, no m_valid, err=1.
//    The next full frame completes normally.
//  5 Assert flush coincident with the 4th s handshake -> sample dropped, wr_idx=0.
//    The following 8 samples form the frame.
//  6 Drop rst_n mid-FEED -> all outputs at reset values within the cycle;
//    after release, a clean frame gives frame_count=1.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state encoding, defaults and index-width helper for the FFT frame feeder
package fft_pkg;

    typedef enum logic [2:0] {
        FILL     = 3'd0,
        START    = 3'd1,
        WAIT_RDY = 3'd2,
        FEED     = 3'd3,
        CAPTURE  = 3'd4,
        DRAIN    = 3'd5
    } state_e;

    localparam int DEF_N  = 8;
    localparam int DEF_DW = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_buf.sv
// rtl/frame_buf.sv - single-frame sample store, one synchronous write port and one asynchronous read port
module frame_buf
    import fft_pkg::*;
#(
    parameter int DEPTH = DEF_N,
    parameter int WIDTH = 2 * DEF_DW,
    parameter int AW    = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - frame-level master: buffer N samples, start and feed the FFT,
// capture its result burst and replay it downstream under backpressure
module fft_frame_feeder
    import fft_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int DATA_WIDTH = DEF_DW,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_real,
    input  logic [DATA_WIDTH-1:0] s_imag,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  fft_start,
    output logic [DATA_WIDTH-1:0] fft_din_real,
    output logic [DATA_WIDTH-1:0] fft_din_imag,
    output logic                  fft_din_valid,
    input  logic                  fft_din_ready,
    input  logic [DATA_WIDTH-1:0] fft_dout_real,
    input  logic [DATA_WIDTH-1:0] fft_dout_imag,
    input  logic                  fft_dout_valid,
    output logic [DATA_WIDTH-1:0] m_real,
    output logic [DATA_WIDTH-1:0] m_imag,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  frame_done,
    output logic                  err_timeout,
    output logic [15:0]           frame_count
);

    localparam int IDXW = idx_width(N);
    localparam int CNTW = $clog2(TIMEOUT + 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);
    localparam logic [CNTW-1:0] WAIT_LAST = CNTW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [CNTW-1:0] wait_q, wait_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic [15:0]     count_q, count_d;
    logic            in_we, out_we;
    logic [2*DATA_WIDTH-1:0] in_rdata, out_rdata;

    // Only one state uses an index at a time, so one shared index serves fill, feed, capture and drain.
    frame_buf #(.DEPTH(N), .WIDTH(2 * DATA_WIDTH), .AW(IDXW)) u_in_buf (
        .clk   (clk),
        .we    (in_we),
        .waddr (idx_q),
        .wdata ({s_real, s_imag}),
        .raddr (idx_q),
        .rdata (in_rdata)
    );

    frame_buf #(.DEPTH(N), .WIDTH(2 * DATA_WIDTH), .AW(IDXW)) u_out_buf (
        .clk   (clk),
        .we    (out_we),
        .waddr (idx_q),
        .wdata ({fft_dout_real, fft_dout_imag}),
        .raddr (idx_q),
        .rdata (out_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        err_d   = err_q;
        done_d  = 1'b0;
        count_d = count_q;
        in_we   = 1'b0;
        out_we  = 1'b0;
        if (flush) begin
            state_d = FILL;
            idx_d   = '0;
            wait_d  = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                FILL: if (s_valid) begin
                    in_we = 1'b1;
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = START;
                end
                START: begin
                    state_d = WAIT_RDY;
                    wait_d  = '0;
                end
                WAIT_RDY: begin
                    if (fft_din_ready) begin
                        state_d = FEED;
                        wait_d  = '0;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = FILL;
                        err_d   = 1'b1;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                FEED: if (fft_din_ready) begin
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = CAPTURE;
                        wait_d  = '0;
                    end
                end
                // The silence counter restarts on every captured sample.
                CAPTURE: begin
                    if (fft_dout_valid) begin
                        out_we = 1'b1;
                        wait_d = '0;
                        idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        if (idx_q == IDX_LAST) state_d = DRAIN;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = FILL;
                        err_d   = 1'b1;
                        idx_d   = '0;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                DRAIN: if (m_ready) begin
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = FILL;
                        done_d  = 1'b1;
                        count_d = count_q + 16'd1;
                    end
                end
                default: begin
                    state_d = FILL;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign s_ready       = (state_q == FILL) && !flush;
    assign fft_start     = (state_q == START);
    assign fft_din_valid = (state_q == FEED);
    assign m_valid       = (state_q == DRAIN);
    // Data outputs are forced to zero outside their states so stale buffer contents never leak.
    assign {fft_din_real, fft_din_imag} = fft_din_valid ? in_rdata : '0;
    assign {m_real, m_imag}             = m_valid ? out_rdata : '0;
    assign frame_done    = done_q;
    assign err_timeout   = err_q;
    assign frame_count   = count_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb/tb_fft_frame_feeder.sv - directed table-driven bench for fft_frame_feeder with an echoing FFT model
module tb_fft_frame_feeder;

    localparam int N  = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic signed [DW-1:0] s_real = '0, s_imag = '0;
    logic s_valid = 1'b0;
    logic s_ready, fft_start, fft_din_valid;
    logic signed [DW-1:0] fft_din_real, fft_din_imag;
    logic fft_din_ready = 1'b0;
    logic signed [DW-1:0] fft_dout_real = '0, fft_dout_imag = '0;
    logic fft_dout_valid = 1'b0;
    logic signed [DW-1:0] m_real, m_imag;
    logic m_valid;
    logic m_ready = 1'b0;
    logic frame_done, err_timeout;
    logic [15:0] frame_count;

    fft_frame_feeder #(.N(N), .DATA_WIDTH(DW), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_real(s_real), .s_imag(s_imag), .s_valid(s_valid), .s_ready(s_ready),
        .fft_start(fft_start),
        .fft_din_real(fft_din_real), .fft_din_imag(fft_din_imag),
        .fft_din_valid(fft_din_valid), .fft_din_ready(fft_din_ready),
        .fft_dout_real(fft_dout_real), .fft_dout_imag(fft_dout_imag),
        .fft_dout_valid(fft_dout_valid),
        .m_real(m_real), .m_imag(m_imag), .m_valid(m_valid), .m_ready(m_ready),
        .frame_done(frame_done), .err_timeout(err_timeout), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [DW-1:0] in_re;
        logic signed [DW-1:0] in_im;
        logic signed [DW-1:0] exp_re;
        logic signed [DW-1:0] exp_im;
    } vec_t;

    vec_t tbl [16];
    logic signed [DW-1:0] cap_re [N];
    logic signed [DW-1:0] cap_im [N];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base, input int cnt);
        int k = 0;
        int n = 0;
        while (k < cnt && n < 100) begin
            s_valid = 1'b1;
            s_real  = tbl[base+k].in_re;
            s_imag  = tbl[base+k].in_im;
            #1;
            if (s_ready) k++;
            n++;
            cyc();
        end
        s_valid = 1'b0;
        chk("fill_count", k, cnt);
    endtask

    task automatic expect_start();
        #1;
        chk("start_latency", fft_start, 1'b1);
        chk("s_ready_low_start", s_ready, 1'b0);
        cyc();
    endtask

    // FFT side: accepts samples; junk on dout meanwhile must be ignored outside CAPTURE.
    task automatic feed(input int base, input int cnt);
        int got = 0;
        int n = 0;
        fft_din_ready  = 1'b1;
        fft_dout_valid = 1'b1;
        fft_dout_real  = 16'sh7777;
        fft_dout_imag  = 16'sh7777;
        while (got < cnt && n < 100) begin
            #1;
            if (fft_din_valid) begin
                chk("din_real", fft_din_real, tbl[base+got].in_re);
                chk("din_imag", fft_din_imag, tbl[base+got].in_im);
                cap_re[got] = fft_din_real;
                cap_im[got] = fft_din_imag;
                got++;
            end
            n++;
            cyc();
        end
        fft_din_ready  = 1'b0;
        fft_dout_valid = 1'b0;
        chk("feed_count", got, cnt);
    endtask

    task automatic capture(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            fft_dout_valid = 1'b1;
            fft_dout_real  = cap_re[i];
            fft_dout_imag  = cap_im[i];
            cyc();
        end
        fft_dout_valid = 1'b0;
    endtask

    task automatic drain(input int base, input int stall_at, input int stall_len, input int exp_count);
        int got = 0;
        int n = 0;
        int st = 0;
        while (got < N && n < 200) begin
            m_ready = !(got == stall_at && st < stall_len);
            #1;
            if (n == 0) chk("m_valid_latency", m_valid, 1'b1);
            if (!m_ready) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_real", m_real, tbl[base+got].exp_re);
                chk("hold_imag", m_imag, tbl[base+got].exp_im);
                chk("hold_s_ready", s_ready, 1'b0);
                st++;
            end else if (m_valid) begin
                chk("m_real", m_real, tbl[base+got].exp_re);
                chk("m_imag", m_imag, tbl[base+got].exp_im);
                got++;
            end
            n++;
            cyc();
        end
        chk("drain_count", got, N);
        #1;
        chk("frame_done_pulse", frame_done, 1'b1);
        chk("frame_count", frame_count, exp_count);
        chk("m_valid_after", m_valid, 1'b0);
        chk("s_ready_after", s_ready, 1'b1);
        cyc();
        chk("frame_done_single", frame_done, 1'b0);
    endtask

    task automatic run_full(input int base, input int stall_at, input int stall_len, input int exp_count);
        fill(base, N);
        expect_start();
        feed(base, N);
        capture(N);
        drain(base, stall_at, stall_len, exp_count);
    endtask

    initial begin
        int seen;
        for (int k = 0; k < 8; k++) begin
            tbl[k].in_re  = 16'(k);
            tbl[k].in_im  = -16'(k);
            tbl[k].exp_re = 16'(k);
            tbl[k].exp_im = -16'(k);
        end
        tbl[8]  = '{16'sh7fff, 16'sh0001, 16'sh7fff, 16'sh0001};
        tbl[9]  = '{16'sh8000, 16'sh0002, 16'sh8000, 16'sh0002};
        tbl[10] = '{16'sh1234, 16'sh0003, 16'sh1234, 16'sh0003};
        tbl[11] = '{16'shffff, 16'sh0004, 16'shffff, 16'sh0004};
        tbl[12] = '{16'sh0055, 16'shfed4, 16'sh0055, 16'shfed4};
        tbl[13] = '{16'shfed4, 16'sh0006, 16'shfed4, 16'sh0006};
        tbl[14] = '{16'sh0000, 16'sh0007, 16'sh0000, 16'sh0007};
        tbl[15] = '{16'sh4321, 16'sh8001, 16'sh4321, 16'sh8001};

        // Reset values
        #12;
        chk("rst_fft_start", fft_start, 1'b0);
        chk("rst_din_valid", fft_din_valid, 1'b0);
        chk("rst_din_real", fft_din_real, 16'h0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_real", m_real, 16'h0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_count", frame_count, 16'h0);
        chk("rst_s_ready", s_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        // 1: plain frame, echo model
        run_full(0, -1, 0, 1);
        chk("done_cnt_t1", done_cnt, 1);

        // 2: downstream stall of 5 cycles mid-drain
        run_full(8, 3, 5, 2);

        // 3: FFT never ready -> WAIT_RDY timeout, then flush clears error
        fill(0, N);
        expect_start();
        repeat (60) cyc();
        #1;
        chk("t3_err_early", err_timeout, 1'b0);
        chk("t3_s_ready_early", s_ready, 1'b0);
        repeat (10) cyc();
        chk("t3_err", err_timeout, 1'b1);
        chk("t3_s_ready", s_ready, 1'b1);
        chk("t3_count", frame_count, 16'd2);
        flush = 1'b1;
        #1;
        chk("t3_flush_s_ready", s_ready, 1'b0);
        cyc();
        flush = 1'b0;
        #1;
        chk("t3_err_cleared", err_timeout, 1'b0);
        cyc();

        // 4: FFT stops after 5 outputs -> CAPTURE timeout, then a normal frame
        fill(0, N);
        expect_start();
        feed(0, N);
        capture(5);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            #1;
            if (m_valid) seen++;
            cyc();
        end
        chk("t4_no_m_valid", seen, 0);
        chk("t4_err", err_timeout, 1'b1);
        chk("t4_s_ready", s_ready, 1'b1);
        chk("t4_count", frame_count, 16'd2);
        run_full(8, -1, 0, 3);

        // 5: flush coincident with the 4th handshake drops the partial frame
        fill(0, 3);
        s_valid = 1'b1;
        s_real  = tbl[3].in_re;
        s_imag  = tbl[3].in_im;
        flush   = 1'b1;
        #1;
        chk("t5_s_ready_flush", s_ready, 1'b0);
        cyc();
        flush   = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("t5_err_cleared", err_timeout, 1'b0);
        chk("t5_no_done", frame_done, 1'b0);
        chk("t5_count", frame_count, 16'd3);
        cyc();
        run_full(8, -1, 0, 4);
        chk("done_cnt_t5", done_cnt, 4);

        // 6: asynchronous reset mid-FEED
        fill(0, N);
        expect_start();
        feed(0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_din_valid", fft_din_valid, 1'b0);
        chk("t6_din_real", fft_din_real, 16'h0);
        chk("t6_din_imag", fft_din_imag, 16'h0);
        chk("t6_fft_start", fft_start, 1'b0);
        chk("t6_m_valid", m_valid, 1'b0);
        chk("t6_count", frame_count, 16'h0);
        chk("t6_err", err_timeout, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        run_full(0, -1, 0, 1);
        chk("done_cnt_t6", done_cnt, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
